// File: rtl/vga_zone_pkg.sv
// Shared types and sizing helpers for the VGA zone grid classifier.
// Zone indices are always at least one bit wide so a 1x1 grid still has ports.
package vga_zone_pkg;

   typedef enum logic [0:0] {
      BROWSE = 1'b0,
      LOCKED = 1'b1
   } zone_state_e;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } zone_dir_e;

   function automatic int idx_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int zid_w(input int cols, input int rows);
      return idx_bits(cols * rows);
   endfunction

endpackage

// File: rtl/zone_cursor_fsm.sv
// Button edge detection, cursor movement and the browse/locked selection FSM.
// The cursor is kept as row/column so edge handling needs no division.
module zone_cursor_fsm
   import vga_zone_pkg::*;
#(
   parameter  int COLS  = 2,
   parameter  int ROWS  = 2,
   parameter  int WRAP  = 1,
   localparam int ZID_W = zid_w(COLS, ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_confirm,
   input  logic             btn_cancel,
   output logic [ZID_W-1:0] cursor_id,
   output logic [ZID_W-1:0] choice_id,
   output logic             locked,
   output logic             confirm_pulse
);

   localparam int CW = idx_bits(COLS);
   localparam int RW = idx_bits(ROWS);

   logic [5:0]    btn_now;
   logic [5:0]    btn_q;
   logic [5:0]    rise;
   zone_dir_e     dir;
   zone_state_e   state;
   logic [RW-1:0] cur_row, row_next;
   logic [CW-1:0] cur_col, col_next;

   assign btn_now   = {btn_cancel, btn_confirm, btn_right, btn_left, btn_down, btn_up};
   assign rise      = btn_now & ~btn_q;
   assign cursor_id = ZID_W'(int'(cur_row) * COLS + int'(cur_col));
   assign locked    = (state == LOCKED);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dir = DIR_NONE;
      if (rise[0])      dir = DIR_UP;
      else if (rise[1]) dir = DIR_DOWN;
      else if (rise[2]) dir = DIR_LEFT;
      else if (rise[3]) dir = DIR_RIGHT;
   end

   always_comb begin
      row_next = cur_row;
      col_next = cur_col;
      case (dir)
         DIR_UP:
            if (cur_row != '0)   row_next = cur_row - RW'(1);
            else if (WRAP != 0)  row_next = RW'(ROWS - 1);
         DIR_DOWN:
            if (cur_row != RW'(ROWS - 1)) row_next = cur_row + RW'(1);
            else if (WRAP != 0)           row_next = '0;
         DIR_LEFT:
            if (cur_col != '0)   col_next = cur_col - CW'(1);
            else if (WRAP != 0)  col_next = CW'(COLS - 1);
         DIR_RIGHT:
            if (cur_col != CW'(COLS - 1)) col_next = cur_col + CW'(1);
            else if (WRAP != 0)           col_next = '0;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q         <= '0;
         state         <= BROWSE;
         cur_row       <= '0;
         cur_col       <= '0;
         choice_id     <= '0;
         confirm_pulse <= 1'b0;
      end else begin
         btn_q         <= btn_now;
         confirm_pulse <= 1'b0;
         if (state == BROWSE) begin
            // Confirm outranks any direction edge arriving in the same cycle.
            if (rise[4]) begin
               choice_id     <= cursor_id;
               confirm_pulse <= 1'b1;
               state         <= LOCKED;
            end else begin
               cur_row <= row_next;
               cur_col <= col_next;
            end
         end else if (rise[5]) begin
            state <= BROWSE;
         end
      end
   end

endmodule

// File: rtl/vga_zone_grid.sv
// Two-stage pixel-to-zone classifier with border/selection flags for the colour mixer.
// The displayed selection is resampled only at frame_start so a frame never shows two selections.
module vga_zone_grid
   import vga_zone_pkg::*;
#(
   parameter  int H_BITS = 10,
   parameter  int V_BITS = 10,
   parameter  int COLS   = 2,
   parameter  int ROWS   = 2,
   parameter  int X0     = 0,
   parameter  int Y0     = 0,
   parameter  int ZONE_W = 320,
   parameter  int ZONE_H = 240,
   parameter  int BORDER = 2,
   parameter  int WRAP   = 1,
   localparam int ZID_W  = zid_w(COLS, ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_valid,
   input  logic [H_BITS-1:0] hcount,
   input  logic [V_BITS-1:0] vcount,
   input  logic              frame_start,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              btn_confirm,
   input  logic              btn_cancel,
   output logic              zone_valid,
   output logic [ZID_W-1:0]  zone_id,
   output logic              zone_outside,
   output logic              zone_border,
   output logic              zone_selected,
   output logic [ZID_W-1:0]  cursor_id,
   output logic [ZID_W-1:0]  choice_id,
   output logic              locked,
   output logic              confirm_pulse
);

   localparam int CW = idx_bits(COLS);
   localparam int RW = idx_bits(ROWS);

   // Grid and border limits, one bit wider than the coordinates so sums cannot wrap.
   localparam logic [H_BITS:0] X_LO  = (H_BITS+1)'(X0);
   localparam logic [H_BITS:0] X_HI  = (H_BITS+1)'(X0 + COLS * ZONE_W);
   localparam logic [V_BITS:0] Y_LO  = (V_BITS+1)'(Y0);
   localparam logic [V_BITS:0] Y_HI  = (V_BITS+1)'(Y0 + ROWS * ZONE_H);
   localparam logic [H_BITS:0] XB_LO = (H_BITS+1)'(BORDER);
   localparam logic [H_BITS:0] XB_HI = (H_BITS+1)'(ZONE_W - BORDER);
   localparam logic [V_BITS:0] YB_LO = (V_BITS+1)'(BORDER);
   localparam logic [V_BITS:0] YB_HI = (V_BITS+1)'(ZONE_H - BORDER);

   logic [CW-1:0]     col_c, s1_col;
   logic [RW-1:0]     row_c, s1_row;
   logic [H_BITS-1:0] xoff_c, s1_xoff;
   logic [V_BITS-1:0] yoff_c, s1_yoff;
   logic              out_c, s1_out, s1_valid;
   logic [ZID_W-1:0]  zid_c, shown_sel;
   logic              border_c, sel_c;

   always_comb begin
      col_c  = '0;
      row_c  = '0;
      xoff_c = '0;
      yoff_c = '0;
      // Bounds rise with the index, so the last match is the largest qualifying zone.
      for (int c = 0; c < COLS; c++) begin
         if ({1'b0, hcount} >= (H_BITS+1)'(X0 + c * ZONE_W)) begin
            col_c  = CW'(c);
            xoff_c = H_BITS'({1'b0, hcount} - (H_BITS+1)'(X0 + c * ZONE_W));
         end
      end
      for (int r = 0; r < ROWS; r++) begin
         if ({1'b0, vcount} >= (V_BITS+1)'(Y0 + r * ZONE_H)) begin
            row_c  = RW'(r);
            yoff_c = V_BITS'({1'b0, vcount} - (V_BITS+1)'(Y0 + r * ZONE_H));
         end
      end
      out_c = ({1'b0, hcount} < X_LO) || ({1'b0, hcount} >= X_HI) ||
              ({1'b0, vcount} < Y_LO) || ({1'b0, vcount} >= Y_HI);
   end

   always_comb begin
      zid_c    = s1_out ? '0 : ZID_W'(int'(s1_row) * COLS + int'(s1_col));
      border_c = !s1_out &&
                 (({1'b0, s1_xoff} < XB_LO) || ({1'b0, s1_xoff} >= XB_HI) ||
                  ({1'b0, s1_yoff} < YB_LO) || ({1'b0, s1_yoff} >= YB_HI));
      sel_c    = !s1_out && (zid_c == shown_sel);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid      <= 1'b0;
         s1_col        <= '0;
         s1_row        <= '0;
         s1_xoff       <= '0;
         s1_yoff       <= '0;
         s1_out        <= 1'b0;
         zone_valid    <= 1'b0;
         zone_id       <= '0;
         zone_outside  <= 1'b0;
         zone_border   <= 1'b0;
         zone_selected <= 1'b0;
      end else begin
         s1_valid      <= pix_valid;
         s1_col        <= col_c;
         s1_row        <= row_c;
         s1_xoff       <= xoff_c;
         s1_yoff       <= yoff_c;
         s1_out        <= out_c;
         zone_valid    <= s1_valid;
         zone_id       <= zid_c;
         zone_outside  <= s1_out;
         zone_border   <= border_c;
         zone_selected <= sel_c;
      end
   end

   // Samples the registered cursor, so a move in the same cycle is seen next frame.
   always_ff @(posedge clk) begin
      if (reset)            shown_sel <= '0;
      else if (frame_start) shown_sel <= locked ? choice_id : cursor_id;
   end

   zone_cursor_fsm #(
      .COLS (COLS),
      .ROWS (ROWS),
      .WRAP (WRAP)
   ) u_cursor_fsm (
      .clk           (clk),
      .reset         (reset),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_confirm   (btn_confirm),
      .btn_cancel    (btn_cancel),
      .cursor_id     (cursor_id),
      .choice_id     (choice_id),
      .locked        (locked),
      .confirm_pulse (confirm_pulse)
   );

endmodule

// File: tb/tb_vga_zone_grid.sv
// Three grid configurations driven from shared inputs, checked against an arithmetic model.
// Pixel results go through per-instance scoreboards; cursor state is compared after each button action.
module tb_vga_zone_grid;

   localparam int P_COLS [3] = '{2, 4, 2};
   localparam int P_ROWS [3] = '{2, 4, 2};
   localparam int P_X0   [3] = '{0, 16, 0};
   localparam int P_Y0   [3] = '{0, 16, 0};
   localparam int P_ZW   [3] = '{320, 64, 320};
   localparam int P_ZH   [3] = '{240, 64, 240};
   localparam int P_BRD  [3] = '{2, 2, 2};
   localparam int P_WRAP [3] = '{1, 1, 0};

   typedef struct {
      int id;
      int outside;
      int border;
      int selected;
   } zexp_t;

   logic       clk = 1'b0;
   logic       reset, pix_valid, frame_start;
   logic [9:0] hcount, vcount;
   logic       btn_up, btn_down, btn_left, btn_right, btn_confirm, btn_cancel;

   logic       zv_a, zout_a, zbrd_a, zsel_a, lck_a, cp_a;
   logic [1:0] zid_a, cur_a, cho_a;
   logic       zv_b, zout_b, zbrd_b, zsel_b, lck_b, cp_b;
   logic [3:0] zid_b, cur_b, cho_b;
   logic       zv_c, zout_c, zbrd_c, zsel_c, lck_c, cp_c;
   logic [1:0] zid_c, cur_c, cho_c;

   int    n_cmp = 0;
   int    n_bad = 0;
   zexp_t q0[$], q1[$], q2[$];
   int    m_cur [3], m_cho [3], m_shown [3];
   int    m_lck [3], m_pulse [3];

   always #5 clk = ~clk;

   vga_zone_grid dut_a (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount),
      .frame_start(frame_start), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
      .zone_valid(zv_a), .zone_id(zid_a), .zone_outside(zout_a), .zone_border(zbrd_a),
      .zone_selected(zsel_a), .cursor_id(cur_a), .choice_id(cho_a), .locked(lck_a),
      .confirm_pulse(cp_a));

   vga_zone_grid #(.COLS(4), .ROWS(4), .X0(16), .Y0(16), .ZONE_W(64), .ZONE_H(64)) dut_b (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount),
      .frame_start(frame_start), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
      .zone_valid(zv_b), .zone_id(zid_b), .zone_outside(zout_b), .zone_border(zbrd_b),
      .zone_selected(zsel_b), .cursor_id(cur_b), .choice_id(cho_b), .locked(lck_b),
      .confirm_pulse(cp_b));

   vga_zone_grid #(.WRAP(0)) dut_c (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount),
      .frame_start(frame_start), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
      .zone_valid(zv_c), .zone_id(zid_c), .zone_outside(zout_c), .zone_border(zbrd_c),
      .zone_selected(zsel_c), .cursor_id(cur_c), .choice_id(cho_c), .locked(lck_c),
      .confirm_pulse(cp_c));

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic zexp_t zmodel(input int d, input int h, input int v);
      zexp_t e;
      int gx, gy, xo, yo;
      e  = '{0, 0, 0, 0};
      gx = h - P_X0[d];
      gy = v - P_Y0[d];
      e.outside = int'(gx < 0 || gx >= P_COLS[d] * P_ZW[d] || gy < 0 || gy >= P_ROWS[d] * P_ZH[d]);
      if (e.outside == 0) begin
         xo = gx % P_ZW[d];
         yo = gy % P_ZH[d];
         e.id = (gy / P_ZH[d]) * P_COLS[d] + gx / P_ZW[d];
         e.border = int'(xo < P_BRD[d] || xo >= P_ZW[d] - P_BRD[d] ||
                         yo < P_BRD[d] || yo >= P_ZH[d] - P_BRD[d]);
         e.selected = int'(e.id == m_shown[d]);
      end
      return e;
   endfunction

   // dir: 0 up, 1 down, 2 left, 3 right
   function automatic int mv(input int d, input int cur, input int dir);
      int r, c;
      r = cur / P_COLS[d];
      c = cur % P_COLS[d];
      case (dir)
         0: if (r > 0) r--; else if (P_WRAP[d] != 0) r = P_ROWS[d] - 1;
         1: if (r < P_ROWS[d] - 1) r++; else if (P_WRAP[d] != 0) r = 0;
         2: if (c > 0) c--; else if (P_WRAP[d] != 0) c = P_COLS[d] - 1;
         3: if (c < P_COLS[d] - 1) c++; else if (P_WRAP[d] != 0) c = 0;
         default: ;
      endcase
      return r * P_COLS[d] + c;
   endfunction

   task automatic pop_cmp(input int d, input int id, input int o, input int b, input int s);
      zexp_t e;
      int    got;
      got = 0;
      case (d)
         0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
      endcase
      if (got == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_valid dut%0d: got zone_valid=1, expected no pixel", d);
      end else begin
         check($sformatf("zone_id dut%0d", d), id, e.id);
         check($sformatf("zone_outside dut%0d", d), o, e.outside);
         check($sformatf("zone_border dut%0d", d), b, e.border);
         check($sformatf("zone_selected dut%0d", d), s, e.selected);
      end
   endtask

   always @(negedge clk) if (!reset && zv_a) pop_cmp(0, int'(zid_a), int'(zout_a), int'(zbrd_a), int'(zsel_a));
   always @(negedge clk) if (!reset && zv_b) pop_cmp(1, int'(zid_b), int'(zout_b), int'(zbrd_b), int'(zsel_b));
   always @(negedge clk) if (!reset && zv_c) pop_cmp(2, int'(zid_c), int'(zout_c), int'(zbrd_c), int'(zsel_c));

   task automatic pix(input int h, input int v, input bit valid);
      hcount    = 10'(h);
      vcount    = 10'(v);
      pix_valid = valid;
      if (valid) begin
         q0.push_back(zmodel(0, h, v));
         q1.push_back(zmodel(1, h, v));
         q2.push_back(zmodel(2, h, v));
      end
      step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      pix_valid = 1'b0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < 10) begin
         step();
         n++;
      end
      check("drain_pending", q0.size() + q1.size() + q2.size(), 0);
   endtask

   task automatic check_fsm(input string tag);
      check({tag, " cursor a"}, int'(cur_a), m_cur[0]);
      check({tag, " cursor b"}, int'(cur_b), m_cur[1]);
      check({tag, " cursor c"}, int'(cur_c), m_cur[2]);
      check({tag, " choice a"}, int'(cho_a), m_cho[0]);
      check({tag, " choice b"}, int'(cho_b), m_cho[1]);
      check({tag, " locked a"}, int'(lck_a), m_lck[0]);
      check({tag, " locked c"}, int'(lck_c), m_lck[2]);
      check({tag, " pulse a"},  int'(cp_a),  m_pulse[0]);
      check({tag, " pulse b"},  int'(cp_b),  m_pulse[1]);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " a"}, int'({zv_a, zid_a, zout_a, zbrd_a, zsel_a, cur_a, cho_a, lck_a, cp_a}), 0);
      check({tag, " b"}, int'({zv_b, zid_b, zout_b, zbrd_b, zsel_b, cur_b, cho_b, lck_b, cp_b}), 0);
      check({tag, " c"}, int'({zv_c, zid_c, zout_c, zbrd_c, zsel_c, cur_c, cho_c, lck_c, cp_c}), 0);
   endtask

   // mask bits: 0 up, 1 down, 2 left, 3 right, 4 confirm, 5 cancel
   task automatic press(input bit [5:0] mask, input bit fs, input int hold);
      int dir;
      dir = -1;
      for (int b = 0; b < 4; b++) if (dir < 0 && mask[b]) dir = b;
      for (int d = 0; d < 3; d++) begin
         if (fs) m_shown[d] = (m_lck[d] != 0) ? m_cho[d] : m_cur[d];
         m_pulse[d] = 0;
         if (m_lck[d] == 0) begin
            if (mask[4]) begin
               m_cho[d]   = m_cur[d];
               m_lck[d]   = 1;
               m_pulse[d] = 1;
            end else if (dir >= 0) begin
               m_cur[d] = mv(d, m_cur[d], dir);
            end
         end else if (mask[5]) begin
            m_lck[d] = 0;
         end
      end
      {btn_cancel, btn_confirm, btn_right, btn_left, btn_down, btn_up} = mask;
      frame_start = fs;
      step();
      frame_start = 1'b0;
      check_fsm("press");
      for (int d = 0; d < 3; d++) m_pulse[d] = 0;
      for (int k = 1; k < hold; k++) begin
         step();
         check_fsm("hold");
      end
      {btn_cancel, btn_confirm, btn_right, btn_left, btn_down, btn_up} = 6'b0;
      step();
      check_fsm("release");
   endtask

   task automatic scan(input int n);
      int h, v, d;
      for (int i = 0; i < n; i++) begin
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) h = int'($urandom_range(0, 1023));
         else h = P_X0[d] + int'($urandom_range(0, P_COLS[d])) * P_ZW[d] + int'($urandom_range(0, 4)) - 2;
         if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 1023));
         else v = P_Y0[d] + int'($urandom_range(0, P_ROWS[d])) * P_ZH[d] + int'($urandom_range(0, 4)) - 2;
         if (h < 0) h = 0;
         if (h > 1023) h = 1023;
         if (v < 0) v = 0;
         if (v > 1023) v = 1023;
         pix(h, v, $urandom_range(0, 3) != 0);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_cur[d] = 0; m_cho[d] = 0; m_shown[d] = 0; m_lck[d] = 0; m_pulse[d] = 0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [5:0] mask;
      model_reset();
      reset = 1'b1; pix_valid = 1'b1; frame_start = 1'b0; hcount = 10'd5; vcount = 10'd5;
      {btn_cancel, btn_confirm, btn_right, btn_left, btn_down, btn_up} = 6'b0;
      step(); step(); step();
      check_zero("reset_state");
      reset = 1'b0;
      pix_valid = 1'b0;

      // Default-grid corners plus the offset-grid edge cases.
      pix(0, 0, 1); pix(319, 239, 1); pix(320, 239, 1); pix(639, 479, 1);
      pix(15, 20, 1); pix(16, 16, 1); pix(18, 18, 1); pix(79, 50, 1); pix(272, 20, 1);
      pix(640, 100, 0); pix(100, 480, 1);
      drain();

      press(6'b001000, 0, 1);   // right
      press(6'b001000, 0, 1);   // right: wraps on a, holds on c
      press(6'b000010, 0, 1);   // down
      press(6'b001001, 0, 1);   // up+right together: up only

      // Mid-frame move is not displayed until frame_start.
      press(6'b001000, 0, 1);
      pix(10, 10, 1); pix(330, 10, 1); pix(100, 300, 1);
      drain();
      press(6'b000000, 1, 1);
      pix(10, 10, 1); pix(330, 10, 1); pix(100, 300, 1);
      drain();
      press(6'b001000, 1, 1);   // frame_start with a move samples the old cursor
      pix(10, 10, 1); pix(330, 10, 1); pix(20, 20, 1);
      drain();

      press(6'b000010, 0, 3);   // held level moves once
      press(6'b010010, 0, 1);   // confirm outranks down
      press(6'b001000, 0, 1);   // ignored while locked
      press(6'b010000, 0, 1);   // ignored while locked
      press(6'b000000, 1, 1);   // display the choice
      pix(10, 10, 1); pix(330, 250, 1); pix(100, 300, 1);
      drain();
      press(6'b100000, 0, 1);   // cancel
      press(6'b100000, 0, 1);   // cancel ignored in browse
      press(6'b010000, 0, 1);   // lock again for the reset test

      pix(100, 100, 1); pix(400, 300, 1);
      reset = 1'b1;
      pix_valid = 1'b0;
      step();
      q0.delete(); q1.delete(); q2.delete();
      model_reset();
      check_zero("reset_mid_frame");
      reset = 1'b0;
      pix(200, 50, 1);
      check("release_zv a", int'(zv_a), 0);
      check("release_zv b", int'(zv_b), 0);
      check("release_zv c", int'(zv_c), 0);
      check_fsm("after_reset");
      drain();
      press(6'b000100, 0, 1);   // left from 0 proves browse mode after reset

      for (int it = 0; it < 60; it++) begin
         scan(int'($urandom_range(4, 16)));
         drain();
         mask = 6'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) mask[4] = 1'b1;
         if ($urandom_range(0, 3) == 0) mask[5] = 1'b1;
         press(mask, $urandom_range(0, 2) == 0, int'($urandom_range(1, 2)));
      end
      scan(20);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_zone_grid.md
Name: vga_zone_grid

Overview:
Parametrised screen-zone classifier and selection controller for the VGA application layer. It maps each pixel coordinate onto a COLS x ROWS grid of equal rectangular zones through a 2-stage pipeline. It also runs a button-driven cursor/confirm state machine and flags pixels that lie in the displayed selection or on a zone border, for the colour mixer downstream. Selection changes reach the display only at frame boundaries, so no frame tears.

Parameters:
H_BITS, 10, width of horizontal coordinate
V_BITS, 10, width of vertical coordinate
COLS, 2, zone columns (1..8)
ROWS, 2, zone rows (1..8)
X0, 0, left edge of grid in pixels
Y0, 0, top edge of grid in pixels
ZONE_W, 320, zone width in pixels
ZONE_H, 240, zone height in pixels
BORDER, 2, border thickness in pixels (0 disables border)
WRAP, 1, 1 = cursor wraps at grid edges, 0 = cursor saturates

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
pix_valid  in  1  hcount/vcount are an active pixel
hcount  in  H_BITS  pixel x
vcount  in  V_BITS  pixel y
frame_start  in  1  one-cycle pulse at start of vertical blank
btn_up, btn_down, btn_left, btn_right  in  1 each  synchronised, debounced levels
btn_confirm, btn_cancel  in  1 each  synchronised, debounced levels
zone_valid  out  1  pix_valid delayed 2 cycles
zone_id  out  ZID_W  row*COLS+col of the pixel; ZID_W = max(1, clog2(COLS*ROWS))
zone_outside  out  1  pixel lies outside the grid
zone_border  out  1  pixel lies within BORDER px of its zone's edge
zone_selected  out  1  pixel lies in the displayed selection zone
cursor_id  out  ZID_W  live cursor zone
choice_id  out  ZID_W  last confirmed zone
locked  out  1  FSM is in LOCKED
confirm_pulse  out  1  one cycle on confirm

Behaviour:
- Reset (synchronous, active-high, wins over all inputs): every output is 0; cursor, shown_sel and choice are 0; FSM enters BROWSE; button history registers are 0. Reset mid-frame clears the pipeline, so zone_valid is 0 for 2 cycles after reset deasserts.
- Stage 1 (registered):
  - col = largest c with hcount >= X0+c*ZONE_W; row is found the same way from vcount.
  - Outside when hcount < X0, hcount >= X0+COLS*ZONE_W, vcount < Y0, or vcount >= Y0+ROWS*ZONE_H.
  - Register col, row, outside, the x/y offsets within the zone, and pix_valid.
  - Boundary comparisons are unsigned at width H_BITS+1 / V_BITS+1, so sums cannot overflow.
- Stage 2 (registered):
  - zone_id = row*COLS+col, forced to 0 when outside.
  - zone_border = !outside & (xoff<BORDER | xoff>=ZONE_W-BORDER | yoff<BORDER | yoff>=ZONE_H-BORDER).
  - zone_selected = !outside & (zone_id == shown_sel).
- Latency is exactly 2 cycles for every zone_* output. When pix_valid=0, the outputs still update, but zone_valid is 0.
- Button edges: rise_x = btn_x & !btn_x_q. Each level held high produces exactly one edge.
- FSM, BROWSE:
  - Direction edges move the cursor one cell. If several direction edges arrive in the same cycle, priority is up > down > left > right and only one move is applied.
  - At a grid edge: WRAP=1 wraps to the opposite edge within the same row or column; WRAP=0 holds the cursor.
  - A confirm edge (it outranks direction edges in the same cycle) sets choice := cursor, pulses confirm_pulse, and moves to LOCKED next cycle.
- FSM, LOCKED: direction and confirm edges are ignored; a cancel edge returns to BROWSE. In BROWSE, cancel is ignored.
- shown_sel := (locked ? choice : cursor), sampled only on frame_start. If frame_start and a cursor move happen in the same cycle, the pre-move value is sampled.
- cursor_id, choice_id and locked are registered and change the cycle after the causing edge.
- COLS*ROWS == 1: cursor is constant 0 and moves are no-ops.

Decomposition:
- Package vga_zone_pkg: FSM enum (BROWSE, LOCKED), a direction enum, and a function returning ZID_W.
- One sub-module, zone_cursor_fsm, holds the button edge detection, cursor, choice and FSM. The top level holds the pipeline and shown_sel.

Test Plan:
- Defaults, scan points (0,0), (319,239), (320,239), (639,479) with pix_valid=1 -> zone_id 0, 0, 1, 3 two cycles later, zone_valid=1, zone_outside=0.
- X0=16, Y0=16, ZONE_W=ZONE_H=64, COLS=ROWS=4, BORDER=2; points (15,20), (16,16), (18,18), (79,50), (272,20) -> outside=1; border=1 id 0; border=0 id 0; border=1 id 0; outside=1.
- Defaults, WRAP=1: right edge, right edge, down edge -> cursor 1, 0, 2. With WRAP=0 from cursor 1: right edge -> cursor stays 1.
- Up and right edges in the same cycle from cursor 2 -> cursor 0 only. Confirm edge together with a down edge -> confirm_pulse=1 for one cycle, choice 0, locked=1, cursor unchanged.
- Cursor moves mid-frame -> zone_selected follows the old zone until the next frame_start, then follows the new one. While locked, direction edges leave cursor_id unchanged.
- Assert reset while LOCKED with the pipeline full -> all outputs 0 the next cycle, zone_valid 0 for 2 cycles after release, FSM in BROWSE.
